// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master port between N_REQ requesters.
// One burst in flight at a time; R beats are steered back to the granted requester.
module axi_rd_arbiter #(
    parameter int N_REQ = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    s_ARVALID,
    output logic [N_REQ-1:0]    s_ARREADY,
    input  logic [N_REQ*AW-1:0] s_ARADDR,
    input  logic [N_REQ*8-1:0]  s_ARLEN,
    output logic [N_REQ-1:0]    s_RVALID,
    input  logic [N_REQ-1:0]    s_RREADY,
    output logic [DW-1:0]       s_RDATA,
    output logic                s_RLAST,
    output logic [1:0]          s_RRESP,
    output logic                m_ARVALID,
    input  logic                m_ARREADY,
    output logic [AW-1:0]       m_ARADDR,
    output logic [7:0]          m_ARLEN,
    input  logic                m_RVALID,
    output logic                m_RREADY,
    input  logic [DW-1:0]       m_RDATA,
    input  logic                m_RLAST,
    input  logic [1:0]          m_RRESP,
    output logic                rd_err
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]        grant, grant_nxt;
    logic [GW-1:0]        arb_idx;
    logic                 arb_hit;
    logic [2*N_REQ-1:0]   req_rot;
    logic [7:0]           len_q, len_nxt;
    logic [8:0]           beat_cnt, beat_cnt_nxt;
    logic                 rd_err_nxt;

    // Rotate the request vector so bit k is requester rr_ptr+k; first set bit wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = rr_ptr;
        req_rot = {s_ARVALID, s_ARVALID} >> rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!arb_hit && req_rot[k]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign m_ARADDR = s_ARADDR[int'(grant)*AW +: AW];
    assign m_ARLEN  = s_ARLEN[int'(grant)*8 +: 8];
    assign s_RDATA  = m_RDATA;
    assign s_RLAST  = m_RLAST;
    assign s_RRESP  = m_RRESP;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        len_nxt      = len_q;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        rd_err_nxt   = rd_err;
        m_ARVALID    = 1'b0;
        s_ARREADY    = '0;
        s_RVALID     = '0;
        m_RREADY     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    grant_nxt = arb_idx;
                    len_nxt   = s_ARLEN[int'(arb_idx)*8 +: 8];
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_ARVALID = 1'b1;
                s_ARREADY = N_REQ'(m_ARREADY) << grant;
                if (m_ARREADY) begin
                    state_nxt    = DATA;
                    beat_cnt_nxt = '0;
                end
            end
            DATA: begin
                s_RVALID = N_REQ'(m_RVALID) << grant;
                m_RREADY = s_RREADY[grant];
                if (m_RVALID && s_RREADY[grant]) begin
                    beat_cnt_nxt = beat_cnt + 9'd1;
                    // Burst only ends on RLAST; a length disagreement just flags rd_err.
                    if (m_RLAST) begin
                        if (beat_cnt != {1'b0, len_q})
                            rd_err_nxt = 1'b1;
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    end else if (beat_cnt == {1'b0, len_q}) begin
                        rd_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            rd_err   <= rd_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_nxt;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed bursts, a transaction-level ownership model
// checked every cycle, and a simple downstream slave returning data = addr + beat.
module tb_axi_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_ARVALID;
    logic [N-1:0]      s_ARREADY;
    logic [N*AW-1:0]   s_ARADDR;
    logic [N*8-1:0]    s_ARLEN;
    logic [N-1:0]      s_RVALID;
    logic [N-1:0]      s_RREADY = '1;
    logic [DW-1:0]     s_RDATA;
    logic              s_RLAST;
    logic [1:0]        s_RRESP;
    logic              m_ARVALID;
    logic              m_ARREADY;
    logic [AW-1:0]     m_ARADDR;
    logic [7:0]        m_ARLEN;
    logic              m_RVALID = 1'b0;
    logic              m_RREADY;
    logic [DW-1:0]     m_RDATA = '0;
    logic              m_RLAST = 1'b0;
    logic [1:0]        m_RRESP = 2'b00;
    logic              rd_err;

    axi_rd_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST),
        .s_RRESP(s_RRESP),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RLAST(m_RLAST),
        .m_RRESP(m_RRESP), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the port, whether its AR went out, beats seen.
    bit            chk_en = 1'b0;
    int            owner = -1;
    bit            ar_done = 1'b0;
    int            beats = 0;
    int            next_pri = 0;
    bit            m_err = 1'b0;
    logic [AW-1:0] own_addr = '0;
    int            own_len = 0;
    int            rbeats[N];
    int            rvalid_seen[N];
    int            bursts_done = 0;
    int            grant_log[$];
    int            cyc = 0;
    int            last_rlast_cyc = -1;
    int            gap_min = 999;
    int            gap_max = 0;
    logic [AW-1:0] last_ar_addr = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [N-1:0] e_arr, e_rv;
        logic         e_arv, e_rr;
        bit           ar_hs, r_hs, found;
        if (chk_en) begin
            e_arr = '0; e_rv = '0; e_arv = 1'b0; e_rr = 1'b0;
            ar_hs = 1'b0; r_hs = 1'b0; found = 1'b0;
            if (owner >= 0 && !ar_done) begin
                e_arv        = 1'b1;
                e_arr[owner] = m_ARREADY;
                ar_hs        = m_ARREADY;
                chk("m_ARADDR", m_ARADDR, own_addr);
                chk("m_ARLEN", m_ARLEN, own_len);
            end else if (owner >= 0) begin
                e_rv[owner] = m_RVALID;
                e_rr        = s_RREADY[owner];
                r_hs        = m_RVALID && s_RREADY[owner];
            end
            chk("m_ARVALID", m_ARVALID, e_arv);
            chk("s_ARREADY", s_ARREADY, e_arr);
            chk("s_RVALID", s_RVALID, e_rv);
            chk("m_RREADY", m_RREADY, e_rr);
            chk("rd_err", rd_err, m_err);
            for (int i = 0; i < N; i++) if (s_RVALID[i]) rvalid_seen[i]++;
            if (r_hs) begin
                chk("s_RDATA", s_RDATA, own_addr + AW'(beats));
                if (m_RLAST != (beats == own_len)) m_err = 1'b1;
                rbeats[owner]++;
                beats++;
                if (m_RLAST) begin
                    next_pri       = (owner + 1) % N;
                    owner          = -1;
                    bursts_done++;
                    last_rlast_cyc = cyc;
                end
            end else if (ar_hs) begin
                ar_done      = 1'b1;
                beats        = 0;
                last_ar_addr = m_ARADDR;
                if (last_rlast_cyc >= 0) begin
                    if (cyc - last_rlast_cyc < gap_min) gap_min = cyc - last_rlast_cyc;
                    if (cyc - last_rlast_cyc > gap_max) gap_max = cyc - last_rlast_cyc;
                end
            end else if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (next_pri + k) % N;
                    if (!found && s_ARVALID[idx]) begin
                        found    = 1'b1;
                        owner    = idx;
                        ar_done  = 1'b0;
                        own_addr = s_ARADDR[idx*AW +: AW];
                        own_len  = int'(s_ARLEN[idx*8 +: 8]);
                        grant_log.push_back(idx);
                    end
                end
            end
            if (rst) begin
                owner    = -1;
                next_pri = 0;
                m_err    = 1'b0;
            end
        end
    end

    // Downstream slave: AR always accepted, beats back-to-back, optional early RLAST.
    bit            ds_busy = 1'b0;
    logic [AW-1:0] ds_addr = '0;
    int            ds_idx = 0;
    int            ds_last = 0;
    bit            trunc = 1'b0;
    bit            rr_toggle = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            ds_busy = 1'b0;
        end else begin
            if (m_RVALID && m_RREADY) begin
                if (m_RLAST) ds_busy = 1'b0;
                else ds_idx++;
            end
            if (m_ARVALID && m_ARREADY) begin
                ds_busy = 1'b1;
                ds_addr = m_ARADDR;
                ds_idx  = 0;
                ds_last = trunc ? int'(m_ARLEN) - 1 : int'(m_ARLEN);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_RVALID = ds_busy;
        m_RDATA  = ds_addr + DW'(ds_idx);
        m_RLAST  = ds_busy && (ds_idx == ds_last);
        s_RREADY = rr_toggle ? ~s_RREADY : '1;
    end

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        s_ARVALID[i]           = 1'b1;
        s_ARADDR[i*AW +: AW]   = a;
        s_ARLEN[i*8 +: 8]      = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_ARREADY[i]) break;
        end
        chk("ar_handshake", s_ARREADY[i], 1'b1);
        @(posedge clk);
        #1 s_ARVALID[i] = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            if (bursts_done >= target) break;
        end
        chk("burst_complete", bursts_done >= target, 1'b1);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            rbeats[i]      = 0;
            rvalid_seen[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        s_ARVALID = '0;
        s_ARADDR  = '0;
        s_ARLEN   = '0;
        m_ARREADY = 1'b1;
        clear_counts();
        @(posedge clk);
        #1 chk_en = 1'b1;
        chk("rst_m_ARVALID", m_ARVALID, 1'b0);
        chk("rst_s_ARREADY", s_ARREADY, 2'b00);
        chk("rst_s_RVALID", s_RVALID, 2'b00);
        chk("rst_m_RREADY", m_RREADY, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single 4-beat burst for requester 0
        clear_counts();
        issue(0, 32'h1000, 8'd3);
        wait_bursts(1);
        chk("t1_beats_req0", rbeats[0], 4);
        chk("t1_beats_req1", rbeats[1], 0);
        chk("t1_araddr", last_ar_addr, 32'h1000);
        chk("t1_rd_err", rd_err, 1'b0);

        // Simultaneous requests from rr_ptr=0: req0 then req1, pointer wraps back to 0
        do_reset();
        clear_counts();
        grant_log.delete();
        fork
            issue(0, 32'h1800, 8'd1);
            issue(1, 32'h2000, 8'd2);
        join
        wait_bursts(3);
        chk("t2_first_grant", grant_log[0], 0);
        chk("t2_second_grant", grant_log[1], 1);
        chk("t2_araddr", last_ar_addr, 32'h2000);
        chk("t2_beats_req1", rbeats[1], 3);
        fork
            issue(0, 32'h1900, 8'd0);
            issue(1, 32'h2100, 8'd0);
        join
        wait_bursts(5);
        chk("t2_wrap_grant", grant_log[2], 0);

        // Requester 1 alone, three single-beat bursts back to back
        clear_counts();
        last_rlast_cyc = -1;
        gap_min = 999;
        gap_max = 0;
        for (int k = 0; k < 3; k++) issue(1, 32'h3000 + 32'(16 * k), 8'd0);
        wait_bursts(8);
        chk("t3_beats_req1", rbeats[1], 3);
        chk("t3_rvalid0_seen", rvalid_seen[0], 0);
        chk("t3_gap_min", gap_min, 2);
        chk("t3_gap_max", gap_max, 2);

        // Requester ready toggling through an 8-beat burst
        clear_counts();
        rr_toggle = 1'b1;
        issue(0, 32'h4000, 8'd7);
        wait_bursts(9);
        rr_toggle = 1'b0;
        chk("t4_beats_req0", rbeats[0], 8);
        chk("t4_rd_err", rd_err, 1'b0);

        // Early RLAST: sticky rd_err survives a clean burst
        clear_counts();
        trunc = 1'b1;
        issue(0, 32'h5000, 8'd3);
        wait_bursts(10);
        trunc = 1'b0;
        chk("t5_beats_req0", rbeats[0], 3);
        chk("t5_rd_err_set", rd_err, 1'b1);
        issue(1, 32'h6000, 8'd1);
        wait_bursts(11);
        chk("t5_beats_req1", rbeats[1], 2);
        chk("t5_rd_err_sticky", rd_err, 1'b1);

        // Reset mid-burst, after leaving rr_ptr at 1
        issue(0, 32'h6800, 8'd0);
        wait_bursts(12);
        clear_counts();
        issue(0, 32'h7000, 8'd5);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (rbeats[0] >= 2) break;
        end
        chk("t6_two_beats", rbeats[0], 2);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_m_ARVALID", m_ARVALID, 1'b0);
        chk("t6_s_ARREADY", s_ARREADY, 2'b00);
        chk("t6_s_RVALID", s_RVALID, 2'b00);
        chk("t6_m_RREADY", m_RREADY, 1'b0);
        chk("t6_rd_err", rd_err, 1'b0);
        grant_log.delete();
        fork
            issue(0, 32'h7100, 8'd0);
            issue(1, 32'h7200, 8'd0);
        join
        wait_bursts(14);
        chk("t6_grant_after_rst", grant_log[0], 0);
        chk("t6_rd_err_clean", rd_err, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
